// File: rtl/bad_point_pkg.sv
// Shared constants for the manual bad-point table: sizes, state encoding,
// coordinate field layout and error-bit positions.
package bad_point_pkg;

    localparam int unsigned WIDTH_BITS    = 10;
    localparam int unsigned HEIGHT_BITS   = 10;
    localparam int unsigned BAD_POINT_NUM = 128;
    localparam int unsigned BAD_POINT_BIT = 7;
    localparam int unsigned IMAGE_WIDTH   = 640;
    localparam int unsigned IMAGE_HEIGHT  = 512;
    localparam int unsigned DATA_BITS     = 32;
    localparam int unsigned CNT_BITS      = BAD_POINT_BIT + 1;
    localparam int unsigned RAM_DEPTH     = 2 * BAD_POINT_NUM;

    localparam int unsigned X_LSB = 0;
    localparam int unsigned X_MSB = 15;
    localparam int unsigned Y_LSB = 16;
    localparam int unsigned Y_MSB = 31;

    localparam int unsigned ERR_RANGE = 0;
    localparam int unsigned ERR_DROP  = 1;

    localparam logic [CNT_BITS-1:0] MAX_NUM = CNT_BITS'(BAD_POINT_NUM);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2,
        ST_ACTIVE  = 2'd3
    } state_t;

    // True when either coordinate lies outside the image.
    function automatic logic coord_out_of_range(input logic [DATA_BITS-1:0] d);
        logic [X_MSB-X_LSB:0] x;
        logic [Y_MSB-Y_LSB:0] y;
        logic x_bad;
        logic y_bad;
        x = d[X_MSB:X_LSB];
        y = d[Y_MSB:Y_LSB];
        x_bad = (|x[X_MSB-X_LSB:WIDTH_BITS]) ||
                (x[WIDTH_BITS-1:0] >= WIDTH_BITS'(IMAGE_WIDTH));
        y_bad = (|y[Y_MSB-Y_LSB:HEIGHT_BITS]) ||
                (y[HEIGHT_BITS-1:0] >= HEIGHT_BITS'(IMAGE_HEIGHT));
        return x_bad || y_bad;
    endfunction

    // Clamp a requested entry count to the bank size.
    function automatic logic [CNT_BITS-1:0] clamp_num(input logic [CNT_BITS-1:0] n);
        return (n > MAX_NUM) ? MAX_NUM : n;
    endfunction

endpackage

// File: rtl/bad_point_bank_ram.sv
// Two-bank coordinate RAM: one bank-selected write port and two independent
// synchronous read ports (scan and debug), each with its own bank select.
module bad_point_bank_ram
    import bad_point_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic                     wbank,
    input  logic [BAD_POINT_BIT-1:0] waddr,
    input  logic [DATA_BITS-1:0]     wdata,
    input  logic                     scan_ren,
    input  logic                     scan_bank,
    input  logic [BAD_POINT_BIT-1:0] scan_addr,
    output logic [DATA_BITS-1:0]     scan_rdata,
    input  logic                     dbg_ren,
    input  logic                     dbg_bank,
    input  logic [BAD_POINT_BIT-1:0] dbg_addr,
    output logic [DATA_BITS-1:0]     dbg_rdata
);

    logic [DATA_BITS-1:0] mem [RAM_DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[{wbank, waddr}] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_rdata <= '0;
        end else if (scan_ren) begin
            scan_rdata <= mem[{scan_bank, scan_addr}];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_rdata <= '0;
        end else if (dbg_ren) begin
            dbg_rdata <= mem[{dbg_bank, dbg_addr}];
        end
    end

endmodule

// File: rtl/bad_point_table_ctrl.sv
// Active/shadow bad-point table controller: shadow writes, SOF-aligned commit,
// and scan/debug arbitration on the active-bank read port.
module bad_point_table_ctrl
    import bad_point_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     cfg_wen,
    input  logic [BAD_POINT_BIT-1:0] cfg_waddr,
    input  logic [DATA_BITS-1:0]     cfg_wdata,
    input  logic [CNT_BITS-1:0]      cfg_num,
    input  logic                     cfg_commit,
    output logic                     commit_pending,
    output logic                     table_valid,
    output logic                     active_bank,
    output logic [CNT_BITS-1:0]      active_num,
    input  logic                     scan_req,
    input  logic [BAD_POINT_BIT-1:0] scan_addr,
    output logic [DATA_BITS-1:0]     scan_rdata,
    output logic                     scan_rvalid,
    input  logic                     dbg_req,
    input  logic                     dbg_sel_active,
    input  logic [BAD_POINT_BIT-1:0] dbg_addr,
    output logic                     dbg_ack,
    output logic [DATA_BITS-1:0]     dbg_rdata,
    output logic [1:0]               cfg_err,
    input  logic                     err_clr
);

    state_t              state;
    logic                sof_q;
    logic [CNT_BITS-1:0] num_latched;

    logic       sof_edge_c;
    logic       open_c;
    logic       wr_ok_c;
    logic       wr_drop_c;
    logic       dbg_grant_c;
    logic       dbg_bank_c;
    logic [1:0] new_err_c;

    // Writes and commits are only accepted while no commit is in flight.
    always_comb begin
        sof_edge_c  = frame_start & ~sof_q;
        open_c      = (state == ST_EMPTY) || (state == ST_ACTIVE);
        wr_ok_c     = rst_n & cfg_wen & open_c;
        wr_drop_c   = cfg_wen & ~open_c;
        dbg_grant_c = dbg_req & ~dbg_ack & (~dbg_sel_active | ~scan_req);
        dbg_bank_c  = dbg_sel_active ? active_bank : ~active_bank;
        new_err_c            = 2'b00;
        new_err_c[ERR_RANGE] = wr_ok_c & coord_out_of_range(cfg_wdata);
        new_err_c[ERR_DROP]  = wr_drop_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_EMPTY;
            sof_q          <= 1'b0;
            num_latched    <= '0;
            commit_pending <= 1'b0;
            table_valid    <= 1'b0;
            active_bank    <= 1'b0;
            active_num     <= '0;
            cfg_err        <= 2'b00;
            scan_rvalid    <= 1'b0;
            dbg_ack        <= 1'b0;
        end else begin
            sof_q <= frame_start;
            case (state)
                ST_EMPTY, ST_ACTIVE: begin
                    // A commit coinciding with SOF waits for the next SOF.
                    if (cfg_commit) begin
                        state          <= ST_PENDING;
                        commit_pending <= 1'b1;
                        num_latched    <= clamp_num(cfg_num);
                    end
                end
                ST_PENDING: begin
                    if (sof_edge_c) begin
                        state          <= ST_SWAP;
                        commit_pending <= 1'b0;
                    end
                end
                ST_SWAP: begin
                    state       <= ST_ACTIVE;
                    active_bank <= ~active_bank;
                    active_num  <= num_latched;
                    table_valid <= 1'b1;
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
            // A new error in the clearing cycle survives the clear.
            cfg_err     <= (err_clr ? 2'b00 : cfg_err) | new_err_c;
            scan_rvalid <= scan_req;
            dbg_ack     <= dbg_grant_c;
        end
    end

    bad_point_bank_ram u_ram (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (wr_ok_c),
        .wbank      (~active_bank),
        .waddr      (cfg_waddr),
        .wdata      (cfg_wdata),
        .scan_ren   (scan_req),
        .scan_bank  (active_bank),
        .scan_addr  (scan_addr),
        .scan_rdata (scan_rdata),
        .dbg_ren    (dbg_grant_c),
        .dbg_bank   (dbg_bank_c),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata)
    );

endmodule

// File: doc/bad_point_table_ctrl.md
Name: bad_point_table_ctrl

Overview:
- Owns the manual bad-point coordinate table for the manual bad-pixel checker, using two banks: an active bank and a shadow bank.
- Host configuration writes always land in the shadow bank. A commit request is held pending and applied only at the next frame_start rising edge, so the table never changes mid-frame.
- Arbitrates the active-bank read port between the checker's scan reads (high priority) and a host debug readback (low priority, req/ack).

Parameters:
- WIDTH_BITS, 10, X coordinate width used for the range check.
- HEIGHT_BITS, 10, Y coordinate width used for the range check.
- BAD_POINT_NUM, 128, entries per bank.
- BAD_POINT_BIT, 7, log2(BAD_POINT_NUM), address width.
- IMAGE_WIDTH, 640, X range limit.
- IMAGE_HEIGHT, 512, Y range limit.

Ports:
- clk  in  1  processing clock
- rst_n  in  1  reset
- frame_start  in  1  SOF level; rising edge is detected internally
- cfg_wen  in  1  shadow-bank write enable
- cfg_waddr  in  BAD_POINT_BIT  write address
- cfg_wdata  in  32  {Y[15:0], X[15:0]}
- cfg_num  in  BAD_POINT_BIT+1  entry count to commit
- cfg_commit  in  1  single-cycle commit request
- commit_pending  out  1  commit waiting for SOF
- table_valid  out  1  at least one table has been swapped in
- active_bank  out  1  bank index currently read by the scan
- active_num  out  BAD_POINT_BIT+1  entry count of the active table
- scan_req  in  1  checker read request
- scan_addr  in  BAD_POINT_BIT  checker read address
- scan_rdata  out  32  active-bank data
- scan_rvalid  out  1  scan data valid
- dbg_req  in  1  debug read request, held until acknowledged
- dbg_sel_active  in  1  1 = read active bank, 0 = read shadow bank
- dbg_addr  in  BAD_POINT_BIT  debug read address
- dbg_ack  out  1  single-cycle acknowledge, coincident with dbg_rdata valid
- dbg_rdata  out  32  debug read data
- cfg_err  out  2  sticky: bit0 out-of-range coordinate, bit1 write dropped while pending
- err_clr  in  1  clears cfg_err

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. All outputs are 0 at reset, including active_bank=0 and active_num=0. State goes to EMPTY. The SOF edge register is cleared. RAM contents are not cleared.
- A reset in mid-operation abandons any pending commit, and table_valid returns to 0.
- States:
  - EMPTY: cfg_commit goes to PENDING.
  - PENDING: SOF rising edge goes to SWAP.
  - SWAP: one cycle, then ACTIVE.
  - ACTIVE: cfg_commit goes to PENDING.
- SWAP actions: active_bank toggles, active_num takes the latched count, table_valid is set to 1, commit_pending is cleared.
  - A scan_req issued in the SOF-edge cycle, or in the SWAP cycle, reads the old bank.
  - The new bank is used from the cycle after SWAP.
- commit_pending is 1 exactly while in PENDING.
- Commit count: latched at cfg_commit as min(cfg_num, BAD_POINT_NUM).
  - A cfg_commit while PENDING is ignored; the first latched count stands.
  - If cfg_commit and an SOF edge occur in the same cycle while in ACTIVE, the state enters PENDING and the swap happens at the following SOF, not the current one.
- Writes:
  - In EMPTY or ACTIVE, cfg_wen writes cfg_wdata to shadow[cfg_waddr].
  - If X ≥ IMAGE_WIDTH or Y ≥ IMAGE_HEIGHT, the entry is still written and cfg_err[0] is set.
  - A write in the same cycle as cfg_commit is performed before the commit takes effect.
  - In PENDING or SWAP, writes are discarded and cfg_err[1] is set.
- err_clr clears cfg_err. If err_clr and a new error occur in the same cycle, the error wins.
- Scan read: 1-cycle latency. scan_rvalid=1 in cycle N+1 for a scan_req in cycle N, regardless of table_valid; the checker gates on table_valid.
- Debug read:
  - A shadow-bank debug read is never blocked; dbg_ack is asserted 1 cycle after the request is sampled.
  - An active-bank debug read is granted only in a cycle with no scan_req; dbg_ack follows 1 cycle after the grant.
  - If scan_req is continuously high, the debug read waits indefinitely (no starvation guard).
  - Only one debug request is outstanding at a time: a new request is sampled only after dbg_ack.
- Bank RAM: 2×BAD_POINT_NUM×32, synchronous read, one write port and two read ports (scan path and debug path), split by bank.

Decomposition:
- Shared package bad_point_pkg:
  - state encoding constants.
  - coordinate field offsets (X = [15:0], Y = [31:16]).
  - cfg_err bit indices.
- Sub-module bad_point_bank_ram:
  - two-bank synchronous RAM with bank-select write and per-port bank-select read.
  - 1-cycle read latency.

Test Plan:
- Write 3 entries (10,10), (100,200), (639,511) to shadow, commit with cfg_num=3. Expect commit_pending=1 until the SOF edge; then active_bank=1, active_num=3, table_valid=1. Scan addr 1 returns 0x00C80064 with rvalid one cycle later.
- Issue scan_req on addr 0 in the SOF-edge cycle → returns old-bank data. Same address two cycles after SWAP → returns new-bank data.
- While PENDING, assert cfg_wen to addr 5 → cfg_err=2'b10, shadow[5] unchanged (check by debug read). Then err_clr → cfg_err=0.
- Write X=640 → entry written, cfg_err[0]=1. Commit with cfg_num=200 → active_num=128 after swap.
- Hold dbg_req with dbg_sel_active=1 while scan_req is high for 5 cycles → no dbg_ack. After scan_req drops, dbg_ack arrives 1 cycle after the grant with correct data. A shadow-bank debug read under the same scan load → dbg_ack after 1 cycle.
- Assert reset while PENDING → commit_pending=0, table_valid=0, active_num=0. The next SOF causes no swap.
